dmem_arbiter: RTL

- Two-port arbiter sharing the single 128x32 data SRAM (CEN/WEN/OEN/A interface, active-low controls) between port 0 (MIPS core load/store path) and port 1 (testbench loader / DMA engine).
- Single-beat transactions with a valid/grant handshake, registered SRAM drive, one-cycle read return, and round-robin arbitration with a bounded burst length.

---
 rtl/dmem_arbiter_if.sv | 32 +++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports and the SRAM pins of the shared data
//   memory arbiter.
//   slave  modport : arbiter side (takes requests, drives grants/SRAM pins)
//   master modport : requester/SRAM side (drives requests and ReadDataMem)
//   Port 0: core load/store path.  Port 1: loader / DMA engine.
interface dmem_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          CEN, WEN, OEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic [DW-1:0] ReadDataMem;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ReadDataMem,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, CEN, WEN, OEN, A, D
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ReadDataMem,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, CEN, WEN, OEN, A, D
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one 128x32 SRAM (active-low CEN/WEN/OEN) between two single-beat
//   requesters. Grants are combinational; the SRAM drive is registered the
//   cycle after a handshake; read data returns one cycle after the access.
//   Arbitration is round-robin with a bounded run of MAX_BURST grants to one
//   port while the other is also requesting.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dmem_arbiter_if.slave (requests, grants, rvalids, SRAM pins)
// Optional feature (macro DMEM_ARB_PERF_EN)
//   perf_gnt0/perf_gnt1 : saturating handshake counts per port
//   perf_stall1         : saturating count of cycles with req1 & ~gnt1
module dmem_arbiter #(
  parameter int AW        = 7,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]  perf_gnt0,
  output logic [15:0]  perf_gnt1,
  output logic [15:0]  perf_stall1
`endif
);

  localparam int          STAGES = 2;
  localparam int          CW     = 4;
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  logic [1:0]          req, gnt;
  logic                hs, sel, sel_we;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;

  logic                owner_q, owner_d;
  logic [CW-1:0]       burst_cnt_q, burst_cnt_d;
  logic                cen_q, cen_d, wen_q, wen_d;
  logic [AW-1:0]       a_q, a_d;
  logic [DW-1:0]       d_q, d_d;
  // per-port read-valid pipe: stage 1 = SRAM access cycle, stage 2 = return
  logic [STAGES:1][1:0] vld_pipe_q, vld_pipe_d;

  assign req = {bus.req1, bus.req0};

  // Grant. A burst count of 0 means the owner went idle last cycle, so it
  // is treated as exhausted and the other port wins the next tie.
  always_comb begin
    gnt = '0;
    if (!rst_n) begin
      gnt = '0;
    end else if (&req) begin
      if (burst_cnt_q == '0 || burst_cnt_q == MAXC) gnt[~owner_q] = 1'b1;
      else                                          gnt[owner_q]  = 1'b1;
    end else begin
      gnt = req;
    end
  end

  assign hs        = |gnt;
  assign sel       = gnt[1];
  assign sel_we    = sel ? bus.we1    : bus.we0;
  assign sel_addr  = sel ? bus.addr1  : bus.addr0;
  assign sel_wdata = sel ? bus.wdata1 : bus.wdata0;

  // Owner / run-length update
  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (hs) begin
      if (sel == owner_q) begin
        burst_cnt_d = (burst_cnt_q == MAXC) ? MAXC : burst_cnt_q + 1'b1;
      end else begin
        owner_d     = sel;
        burst_cnt_d = CW'(1);
      end
    end else begin
      burst_cnt_d = '0;
    end
  end

  // Issue stage and read-return pipe; A/D hold when idle
  always_comb begin
    cen_d         = ~hs;
    wen_d         = hs ? ~sel_we : 1'b1;
    a_d           = hs ? sel_addr  : a_q;
    d_d           = hs ? sel_wdata : d_q;
    vld_pipe_d    = vld_pipe_q;
    vld_pipe_d[1] = (hs && !sel_we) ? gnt : 2'b00;
    vld_pipe_d[2] = vld_pipe_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= 1'b1;
      burst_cnt_q <= '0;
      cen_q       <= 1'b1;
      wen_q       <= 1'b1;
      a_q         <= '0;
      d_q         <= '0;
      vld_pipe_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      cen_q       <= cen_d;
      wen_q       <= wen_d;
      a_q         <= a_d;
      d_q         <= d_d;
      vld_pipe_q  <= vld_pipe_d;
    end
  end

  assign bus.gnt0    = gnt[0];
  assign bus.gnt1    = gnt[1];
  assign bus.rvalid0 = vld_pipe_q[STAGES][0];
  assign bus.rvalid1 = vld_pipe_q[STAGES][1];
  assign bus.rdata   = bus.ReadDataMem;
  assign bus.CEN     = cen_q;
  assign bus.WEN     = wen_q;
  assign bus.OEN     = 1'b0;
  assign bus.A       = a_q;
  assign bus.D       = d_q;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] pg0_q, pg0_d, pg1_q, pg1_d, ps1_q, ps1_d;

  always_comb begin
    pg0_d = pg0_q;
    pg1_d = pg1_q;
    ps1_d = ps1_q;
    if (gnt[0] && pg0_q != 16'hFFFF)            pg0_d = pg0_q + 16'd1;
    if (gnt[1] && pg1_q != 16'hFFFF)            pg1_d = pg1_q + 16'd1;
    if (req[1] && !gnt[1] && ps1_q != 16'hFFFF) ps1_d = ps1_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pg0_q <= '0;
      pg1_q <= '0;
      ps1_q <= '0;
    end else begin
      pg0_q <= pg0_d;
      pg1_q <= pg1_d;
      ps1_q <= ps1_d;
    end
  end

  assign perf_gnt0   = pg0_q;
  assign perf_gnt1   = pg1_q;
  assign perf_stall1 = ps1_q;
`endif

endmodule
